// File: rtl/frame_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : frame_stream_decoder
// Brief    : Receive-side decoder for the RGB565 pixel stream sent to the
//            display controller. Recovers bar levels, health, mode and a
//            sprite-area signature, publishing them once per complete frame.
// Revision : 1.0 - initial release
// ============================================================================
module frame_stream_decoder #(
    parameter int H_PIX = 220,
    parameter int V_PIX = 176,
    parameter int CELL  = 11,
    parameter int SAMP  = 5
) (
    input  logic        clk_input_data,
    input  logic        rst,
    input  logic [15:0] pixel_in,
    input  logic        frame_done,
    output logic [2:0]  hambre_o,
    output logic [2:0]  energia_o,
    output logic [2:0]  diversion_o,
    output logic        salud_o,
    output logic        modo_o,
    output logic [15:0] sprite_sig,
    output logic        frame_valid,
    output logic        format_err,
    output logic        frame_err
);

    localparam logic [15:0] K_LAST   = 16'(H_PIX * V_PIX - 1);
    localparam logic [7:0]  SUB_LAST = 8'(CELL - 1);
    localparam logic [7:0]  SUB_SAMP = 8'(SAMP);
    localparam logic [4:0]  CX_LAST  = 5'(H_PIX / CELL - 1);
    localparam logic [3:0]  CY_LAST  = 4'(V_PIX / CELL - 1);

    localparam logic [15:0] C_WHITE  = 16'hFFFF;
    localparam logic [15:0] C_HUNGER = 16'hFB20;
    localparam logic [15:0] C_ENERGY = 16'h07E0;
    localparam logic [15:0] C_FUN    = 16'hFFE0;
    localparam logic [15:0] C_HEALTH = 16'hF800;
    localparam logic [15:0] C_MODE   = 16'h001F;

    typedef enum logic [1:0] {
        S_SYNC    = 2'd0,
        S_SKIP    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t          state_q;
    logic [15:0]     k_q;
    logic [7:0]      subcol_q;
    logic [7:0]      subrow_q;
    logic [4:0]      cx_q;
    logic [3:0]      cy_q;

    // Shadow state accumulated over the frame being captured
    logic [15:0]     sig_q,   sig_d;
    logic [2:0][3:0] lit_q,   lit_d;     // [bar][band], band 0 is the bottom band
    logic            salud_q, salud_d;
    logic            modo_q,  modo_d;
    logic            err_q,   err_d;

    logic [2:0][2:0] lvl_d;
    logic            thermo_bad_d;
    logic            w_at_samp;
    logic            w_in_sprite;
    logic [1:0]      w_band;

    function automatic logic [15:0] bar_lit(input int b);
        case (b)
            0:       bar_lit = C_HUNGER;
            1:       bar_lit = C_ENERGY;
            default: bar_lit = C_FUN;
        endcase
    endfunction

    // Fold the current pixel into the shadow state and derive frame results
    always_comb begin
        w_at_samp    = (subcol_q == SUB_SAMP) && (subrow_q == SUB_SAMP);
        w_in_sprite  = (cx_q >= 5'd1) && (cx_q <= 5'd13) && (cy_q >= 4'd2) && (cy_q <= 4'd14);
        // Sample rows 14/10/6/2 map to bands 0/1/2/3
        w_band       = 2'd3 - cy_q[3:2];
        sig_d        = sig_q;
        lit_d        = lit_q;
        salud_d      = salud_q;
        modo_d       = modo_q;
        err_d        = err_q;
        thermo_bad_d = 1'b0;

        if (w_in_sprite) begin
            sig_d = {sig_q[14:0], sig_q[15]} ^ pixel_in;
        end

        if (w_at_samp) begin
            if (cy_q[1:0] == 2'd2) begin
                for (int b = 0; b < 3; b++) begin
                    if (cx_q == 5'(17 + b)) begin
                        if (pixel_in == bar_lit(b)) begin
                            lit_d[b][w_band] = 1'b1;
                        end else if (pixel_in != C_WHITE) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            if (cx_q == 5'd16 && cy_q == 4'd2) begin
                if (pixel_in == C_HEALTH)     salud_d = 1'b1;
                else if (pixel_in == C_WHITE) salud_d = 1'b0;
                else                          err_d   = 1'b1;
            end
            if (cx_q == 5'd7 && cy_q == 4'd0) begin
                if (pixel_in == C_MODE)       modo_d = 1'b1;
                else if (pixel_in == C_WHITE) modo_d = 1'b0;
                else                          err_d  = 1'b1;
            end
        end

        // Level is the lit-band count; a lit band above an unlit one is malformed
        for (int b = 0; b < 3; b++) begin
            lvl_d[b] = {2'b00, lit_d[b][0]} + {2'b00, lit_d[b][1]}
                     + {2'b00, lit_d[b][2]} + {2'b00, lit_d[b][3]};
            for (int j = 0; j < 3; j++) begin
                if (lit_d[b][j + 1] && !lit_d[b][j]) begin
                    thermo_bad_d = 1'b1;
                end
            end
        end
    end

    // Frame sync/capture state machine with registered outputs
    always_ff @(posedge clk_input_data or posedge rst) begin
        if (rst) begin
            state_q     <= S_SYNC;
            k_q         <= 16'd0;
            subcol_q    <= 8'd0;
            subrow_q    <= 8'd0;
            cx_q        <= 5'd0;
            cy_q        <= 4'd0;
            sig_q       <= 16'd0;
            lit_q       <= '0;
            salud_q     <= 1'b0;
            modo_q      <= 1'b0;
            err_q       <= 1'b0;
            hambre_o    <= 3'd0;
            energia_o   <= 3'd0;
            diversion_o <= 3'd0;
            salud_o     <= 1'b0;
            modo_o      <= 1'b0;
            sprite_sig  <= 16'd0;
            frame_valid <= 1'b0;
            format_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state_q)
                S_SYNC: begin
                    if (frame_done) state_q <= S_SKIP;
                end
                S_SKIP: begin
                    k_q      <= 16'd0;
                    subcol_q <= 8'd0;
                    subrow_q <= 8'd0;
                    cx_q     <= 5'd0;
                    cy_q     <= 4'd0;
                    sig_q    <= 16'd0;
                    lit_q    <= '0;
                    salud_q  <= 1'b0;
                    modo_q   <= 1'b0;
                    err_q    <= 1'b0;
                    state_q  <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (k_q == K_LAST) begin
                        // Last pixel: publish including this pixel's contribution
                        hambre_o    <= lvl_d[0];
                        energia_o   <= lvl_d[1];
                        diversion_o <= lvl_d[2];
                        salud_o     <= salud_d;
                        modo_o      <= modo_d;
                        sprite_sig  <= sig_d;
                        format_err  <= err_d | thermo_bad_d;
                        frame_valid <= 1'b1;
                        state_q     <= S_SYNC;
                    end else if (frame_done) begin
                        // Early marker: abandon this frame and treat it as the next start
                        frame_err <= 1'b1;
                        state_q   <= S_SKIP;
                    end else begin
                        sig_q   <= sig_d;
                        lit_q   <= lit_d;
                        salud_q <= salud_d;
                        modo_q  <= modo_d;
                        err_q   <= err_d;
                        k_q     <= k_q + 16'd1;
                        if (subcol_q == SUB_LAST) begin
                            subcol_q <= 8'd0;
                            if (cx_q == CX_LAST) begin
                                cx_q <= 5'd0;
                                if (subrow_q == SUB_LAST) begin
                                    subrow_q <= 8'd0;
                                    cy_q     <= (cy_q == CY_LAST) ? 4'd0 : cy_q + 4'd1;
                                end else begin
                                    subrow_q <= subrow_q + 8'd1;
                                end
                            end else begin
                                cx_q <= cx_q + 5'd1;
                            end
                        end else begin
                            subcol_q <= subcol_q + 8'd1;
                        end
                    end
                end
                default: state_q <= S_SYNC;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_stream_decoder
// Brief    : Self-checking bench for frame_stream_decoder on a reduced cell
//            size (3x3 cells, same 20x16 grid) so many frames fit the budget.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_stream_decoder;

    localparam int BC = 3;
    localparam int BS = 1;
    localparam int BH = 20 * BC;
    localparam int BV = 16 * BC;
    localparam int FR = BH * BV;

    typedef struct {
        logic [2:0]  h, e, f;
        logic        sal, mod, ferr;
        logic [15:0] sig;
    } exp_t;

    typedef struct {
        int          h, e, f;
        bit          sal, mod;
        int          corrupt;
        bit          spr_fixed;
        logic [2:0]  eh, ee, ef;
        logic        esal, emod, eferr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pixel_in;
    logic        frame_done;
    logic [2:0]  hambre_o, energia_o, diversion_o;
    logic        salud_o, modo_o;
    logic [15:0] sprite_sig;
    logic        frame_valid, format_err, frame_err;

    logic [15:0] img [FR];
    int          n_chk = 0;
    int          n_err = 0;

    frame_stream_decoder #(
        .H_PIX(BH), .V_PIX(BV), .CELL(BC), .SAMP(BS)
    ) dut (
        .clk_input_data(clk),
        .rst           (rst),
        .pixel_in      (pixel_in),
        .frame_done    (frame_done),
        .hambre_o      (hambre_o),
        .energia_o     (energia_o),
        .diversion_o   (diversion_o),
        .salud_o       (salud_o),
        .modo_o        (modo_o),
        .sprite_sig    (sprite_sig),
        .frame_valid   (frame_valid),
        .format_err    (format_err),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic fd);
        pixel_in   = p;
        frame_done = fd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lit_of(input int b);
        return (b == 0) ? 16'hFB20 : (b == 1) ? 16'h07E0 : 16'hFFE0;
    endfunction

    function automatic int cell_idx(input int cx, input int cy);
        return (cy * BC + BS) * BH + cx * BC + BS;
    endfunction

    // Paint an image: random or white background, optional fixed sprite fill,
    // bar/health/mode sample pixels, then an optional deliberate defect.
    task automatic build_image(input int h, input int e, input int f, input bit sal,
                               input bit mod, input int corrupt, input bit spr_fixed,
                               input bit white);
        int lv;
        for (int k = 0; k < FR; k++) begin
            int r = k / BH;
            int c = k % BH;
            img[k] = white ? 16'hFFFF : 16'($urandom);
            if (spr_fixed && (c / BC) >= 1 && (c / BC) <= 13 && (r / BC) >= 2 && (r / BC) <= 14)
                img[k] = 16'h1234;
        end
        for (int b = 0; b < 3; b++) begin
            lv = (b == 0) ? h : (b == 1) ? e : f;
            for (int j = 0; j < 4; j++)
                img[cell_idx(17 + b, 14 - 4 * j)] = (j < lv) ? lit_of(b) : 16'hFFFF;
        end
        img[cell_idx(16, 2)] = sal ? 16'hF800 : 16'hFFFF;
        img[cell_idx(7, 0)]  = mod ? 16'h001F : 16'hFFFF;
        case (corrupt)
            1: begin
                img[cell_idx(17, 6)] = 16'hFFFF;
                img[cell_idx(17, 2)] = 16'hFB20;
            end
            2: img[cell_idx(18, 14)] = 16'h0000;
            3: img[cell_idx(16, 2)]  = 16'h1234;
            default: ;
        endcase
    endtask

    // Reference decode of the image by row/column arithmetic
    function automatic exp_t model();
        exp_t m;
        bit   lit [4];
        int   cnt;
        logic [15:0] p;
        m.sig = 16'h0;
        m.ferr = 1'b0;
        for (int k = 0; k < FR; k++) begin
            int cxm = (k % BH) / BC;
            int cym = (k / BH) / BC;
            if (cxm >= 1 && cxm <= 13 && cym >= 2 && cym <= 14)
                m.sig = {m.sig[14:0], m.sig[15]} ^ img[k];
        end
        for (int b = 0; b < 3; b++) begin
            cnt = 0;
            for (int j = 0; j < 4; j++) begin
                p = img[cell_idx(17 + b, 14 - 4 * j)];
                lit[j] = (p == lit_of(b));
                if (lit[j]) cnt++;
                else if (p != 16'hFFFF) m.ferr = 1'b1;
            end
            for (int j = 0; j < 3; j++)
                if (lit[j + 1] && !lit[j]) m.ferr = 1'b1;
            if (b == 0) m.h = 3'(cnt);
            else if (b == 1) m.e = 3'(cnt);
            else m.f = 3'(cnt);
        end
        p = img[cell_idx(16, 2)];
        m.sal = (p == 16'hF800);
        if (p != 16'hF800 && p != 16'hFFFF) m.ferr = 1'b1;
        p = img[cell_idx(7, 0)];
        m.mod = (p == 16'h001F);
        if (p != 16'h001F && p != 16'hFFFF) m.ferr = 1'b1;
        return m;
    endfunction

    // Stream one frame; counts any frame_valid/frame_err seen before the end
    task automatic send_frame(input bit lead_fd, input bit shift, output int spur);
        spur = 0;
        if (lead_fd) begin
            drive(16'($urandom), 1'b1);
            if (frame_valid || frame_err) spur++;
        end
        if (!shift) begin
            drive(16'($urandom), 1'b0);
            if (frame_valid || frame_err) spur++;
        end
        for (int k = 0; k < FR; k++) begin
            drive(img[k], 1'b0);
            if ((k < FR - 1 || shift) && (frame_valid || frame_err)) spur++;
        end
        if (shift) drive(16'($urandom), 1'b0);
    endtask

    task automatic chk_frame(input string tag, input exp_t e, input bit skip_sal);
        chk({tag, " frame_valid"}, 32'(frame_valid), 32'd1);
        chk({tag, " frame_err"},   32'(frame_err),   32'd0);
        chk({tag, " hambre"},      32'(hambre_o),    32'(e.h));
        chk({tag, " energia"},     32'(energia_o),   32'(e.e));
        chk({tag, " diversion"},   32'(diversion_o), 32'(e.f));
        if (!skip_sal) chk({tag, " salud"}, 32'(salud_o), 32'(e.sal));
        chk({tag, " modo"},        32'(modo_o),      32'(e.mod));
        chk({tag, " format_err"},  32'(format_err),  32'(e.ferr));
        chk({tag, " sprite_sig"},  32'(sprite_sig),  32'(e.sig));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " levels"},  32'({hambre_o, energia_o, diversion_o}), 32'd0);
        chk({tag, " flags"},   32'({salud_o, modo_o, format_err}), 32'd0);
        chk({tag, " sig"},     32'(sprite_sig), 32'd0);
        chk({tag, " pulses"},  32'({frame_valid, frame_err}), 32'd0);
    endtask

    initial begin
        vec_t tv [5];
        exp_t m, e, last;
        int   spur;
        int   h, en, f;

        rst = 1'b1; pixel_in = 16'h0; frame_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // ---- table-driven frames ----
        tv[0] = '{3, 4, 0, 1'b1, 1'b1, 0, 1'b1, 3'd3, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[1] = '{0, 1, 2, 1'b0, 1'b1, 0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0};
        tv[2] = '{3, 3, 3, 1'b0, 1'b0, 1, 1'b0, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 1'b1};
        tv[3] = '{2, 4, 1, 1'b1, 1'b0, 2, 1'b0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1};
        tv[4] = '{4, 0, 4, 1'b1, 1'b1, 3, 1'b0, 3'd4, 3'd0, 3'd4, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            build_image(tv[i].h, tv[i].e, tv[i].f, tv[i].sal, tv[i].mod,
                        tv[i].corrupt, tv[i].spr_fixed, 1'b0);
            m = model();
            send_frame(1'b1, 1'b0, spur);
            chk($sformatf("vec%0d no early pulse", i), 32'(spur), 32'd0);
            e = '{tv[i].eh, tv[i].ee, tv[i].ef, tv[i].esal, tv[i].emod, tv[i].eferr, m.sig};
            chk_frame($sformatf("vec%0d", i), e, tv[i].corrupt == 3);
        end

        // ---- alignment: first real pixel is F800 in cell (0,0) ----
        build_image(0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        img[0] = 16'hF800;
        m = model();
        send_frame(1'b1, 1'b0, spur);
        chk("align no early pulse", 32'(spur), 32'd0);
        chk_frame("align", '{3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, m.sig}, 1'b0);

        // ---- stream shifted by one pixel must not reproduce the signature ----
        build_image(2, 2, 2, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        m = model();
        send_frame(1'b1, 1'b1, spur);
        chk("shift frame_valid", 32'(frame_valid), 32'd1);
        n_chk++;
        if (sprite_sig === m.sig) begin
            n_err++;
            $display("FAIL shift sprite_sig: got %0h, required to differ from %0h", sprite_sig, m.sig);
        end

        // ---- randomized frames against the reference model ----
        for (int r = 0; r < 4; r++) begin
            build_image($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                        1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b0, 1'b0);
            m = model();
            send_frame(1'b1, 1'b0, spur);
            chk($sformatf("rand%0d no early pulse", r), 32'(spur), 32'd0);
            chk_frame($sformatf("rand%0d", r), m, 1'b0);
            last = m;
        end

        // ---- truncation at k=1000 ----
        build_image(4, 4, 4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        drive(16'($urandom), 1'b1);
        drive(16'($urandom), 1'b0);
        spur = 0;
        for (int k = 0; k < 1000; k++) begin
            drive(img[k], 1'b0);
            if (frame_valid || frame_err) spur++;
        end
        chk("trunc no early pulse", 32'(spur), 32'd0);
        drive(16'($urandom), 1'b1);
        chk("trunc frame_err", 32'(frame_err), 32'd1);
        chk("trunc frame_valid", 32'(frame_valid), 32'd0);
        chk("trunc hold levels", 32'({hambre_o, energia_o, diversion_o}), 32'({last.h, last.e, last.f}));
        chk("trunc hold flags", 32'({salud_o, modo_o, format_err}), 32'({last.sal, last.mod, last.ferr}));
        chk("trunc hold sig", 32'(sprite_sig), 32'(last.sig));
        build_image(1, 2, 3, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        m = model();
        send_frame(1'b0, 1'b0, spur);
        chk("after trunc no early pulse", 32'(spur), 32'd0);
        chk_frame("after trunc", m, 1'b0);

        // ---- reset in mid-capture ----
        build_image(3, 3, 3, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        drive(16'($urandom), 1'b1);
        drive(16'($urandom), 1'b0);
        for (int k = 0; k < 2000; k++) drive(img[k], 1'b0);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        spur = 0;
        for (int i = 0; i < 3; i++) begin
            drive(16'($urandom), 1'b0);
            if (frame_valid || frame_err) spur++;
        end
        chk("midreset no pulse", 32'(spur), 32'd0);
        build_image(2, 0, 4, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        m = model();
        send_frame(1'b1, 1'b0, spur);
        chk("post reset no early pulse", 32'(spur), 32'd0);
        chk_frame("post reset", m, 1'b0);

        // ---- back-to-back frames, hunger 4 then 1 ----
        h = 4; en = 1; f = 2;
        build_image(h, en, f, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        m = model();
        send_frame(1'b1, 1'b0, spur);
        chk("b2b first no early pulse", 32'(spur), 32'd0);
        chk_frame("b2b first", '{3'd4, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, m.sig}, 1'b0);
        h = 1;
        build_image(h, en, f, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        m = model();
        send_frame(1'b1, 1'b0, spur);
        chk("b2b second no glitch", 32'(spur), 32'd0);
        chk_frame("b2b second", '{3'd1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, m.sig}, 1'b0);
        drive(16'($urandom), 1'b0);
        chk("frame_valid drops", 32'(frame_valid), 32'd0);
        chk("hambre holds", 32'(hambre_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
